// File: rtl/fifo_sync_nx_pkg.sv
// fifo_sync_nx_pkg: sizing helpers and default parameters shared by the FIFO files
package fifo_sync_nx_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;
  localparam int AE_TH_DEF  = 2;
  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction
  // one extra wrap bit distinguishes full from empty when the addresses match
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction
  function automatic int af_th_def(input int aw);
    return depth(aw) - 2;
  endfunction
endpackage

// File: rtl/fifo_sync_nx_if.sv
// fifo_sync_nx_if: producer/consumer bus of fifo_sync_nx
// master drives dataIN/wrEN/rdEN/clrERR; slave (the FIFO) drives Q/qValid, level flags, count and error flags
interface fifo_sync_nx_if
  import fifo_sync_nx_pkg::*;
#(
  parameter int dataW = DATA_W_DEF,
  parameter int addrW = ADDR_W_DEF
);
  logic [dataW-1:0] dataIN;
  logic [dataW-1:0] Q;
  logic             wrEN;
  logic             rdEN;
  logic             clrERR;
  logic             qValid;
  logic             full;
  logic             empty;
  logic             almostFull;
  logic             almostEmpty;
  logic [addrW:0]   count;
  logic             overflow;
  logic             underflow;
  modport master(
    output dataIN, wrEN, rdEN, clrERR,
    input  Q, qValid, full, empty, almostFull, almostEmpty, count, overflow, underflow
  );
  modport slave(
    input  dataIN, wrEN, rdEN, clrERR,
    output Q, qValid, full, empty, almostFull, almostEmpty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_nx_ram_dp.sv
// fifo_ram_dp: simple dual-port RAM, synchronous write port and registered read port
// ports: CLK, RESN (clears only the read register), i_we/i_waddr/i_wdata write, i_re/i_raddr read, o_q data
module fifo_ram_dp #(
  parameter int dataW = 8,
  parameter int addrW = 5
) (
  input  logic             CLK,
  input  logic             RESN,
  input  logic             i_we,
  input  logic [addrW-1:0] i_waddr,
  input  logic [dataW-1:0] i_wdata,
  input  logic             i_re,
  input  logic [addrW-1:0] i_raddr,
  output logic [dataW-1:0] o_q
);
  logic [dataW-1:0] r_mem [2**addrW];
  logic [dataW-1:0] r_q;
  always_ff @(posedge CLK)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  // same-address read/write returns the old word, which is what a full FIFO doing both needs
  always_ff @(posedge CLK or negedge RESN)
    if (!RESN) r_q <= '0;
    else if (i_re) r_q <= r_mem[i_raddr];
  assign o_q = r_q;
endmodule

// File: rtl/fifo_sync_nx.sv
// fifo_sync_nx: synchronous FIFO with occupancy count, almost thresholds and sticky error flags
// ports: CLK, RESN (async active-low), bus (fifo_sync_nx_if.slave) carrying data, requests and status
module fifo_sync_nx
  import fifo_sync_nx_pkg::*;
#(
  parameter int dataW = DATA_W_DEF,
  parameter int addrW = ADDR_W_DEF,
  parameter int afTH  = af_th_def(addrW),
  parameter int aeTH  = AE_TH_DEF
) (
  input logic           CLK,
  input logic           RESN,
  fifo_sync_nx_if.slave bus
);
  localparam int PW = ptr_w(addrW);
  localparam logic [PW-1:0] AF = PW'(afTH);
  localparam logic [PW-1:0] AE = PW'(aeTH);
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_count;
  logic [PW-1:0] w_wr_nxt, w_rd_nxt, w_cnt_nxt;
  logic          r_full, r_empty, r_af, r_ae, r_qvalid, r_ovf, r_udf;
  logic          w_wr_acc, w_rd_acc;
  assign w_rd_acc  = bus.rdEN & ~r_empty;
  assign w_wr_acc  = bus.wrEN & (~r_full | w_rd_acc);
  assign w_wr_nxt  = r_wr_ptr + PW'(w_wr_acc);
  assign w_rd_nxt  = r_rd_ptr + PW'(w_rd_acc);
  // pointer difference modulo 2**PW is the occupancy, including the wrap case
  assign w_cnt_nxt = w_wr_nxt - w_rd_nxt;
  always_ff @(posedge CLK or negedge RESN)
    if (!RESN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= (AF == '0);
      r_ae     <= 1'b1;
      r_qvalid <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
      r_full   <= (w_wr_nxt[addrW-1:0] == w_rd_nxt[addrW-1:0]) & (w_wr_nxt[addrW] != w_rd_nxt[addrW]);
      r_empty  <= (w_wr_nxt == w_rd_nxt);
      r_af     <= (w_cnt_nxt >= AF);
      r_ae     <= (w_cnt_nxt <= AE);
      r_qvalid <= w_rd_acc;
      r_ovf    <= (r_ovf & ~bus.clrERR) | (bus.wrEN & ~w_wr_acc);
      r_udf    <= (r_udf & ~bus.clrERR) | (bus.rdEN & ~w_rd_acc);
    end
  fifo_ram_dp #(.dataW(dataW), .addrW(addrW)) u_ram (
    .CLK    (CLK),
    .RESN   (RESN),
    .i_we   (w_wr_acc),
    .i_waddr(r_wr_ptr[addrW-1:0]),
    .i_wdata(bus.dataIN),
    .i_re   (w_rd_acc),
    .i_raddr(r_rd_ptr[addrW-1:0]),
    .o_q    (bus.Q)
  );
  assign bus.qValid      = r_qvalid;
  assign bus.full        = r_full;
  assign bus.empty       = r_empty;
  assign bus.almostFull  = r_af;
  assign bus.almostEmpty = r_ae;
  assign bus.count       = r_count;
  assign bus.overflow    = r_ovf;
  assign bus.underflow   = r_udf;
endmodule
